mem_debug_dumper: RTL and testbench
===================================

# mem_debug_dumper

Debug-side reader of the MEM stage's debug data port. On a start pulse it walks a word range of data memory through the debug address input and captures each returned word. It then streams every word as four bytes, most-significant byte first, over a valid/ready byte interface to the debug UART transmitter. It sits in the debug unit between the MEM stage debug port and the UART TX path, alongside the register-file dump logic.

## Interface
- BITS_SIZE, 32, data and address width; must be 32, since the byte split assumes four bytes per word
- SIZE_MEM_DATA, 10, log2 of data memory depth in words; sets the width of the word-count input
- i_clk  input  1  system clock, rising edge
- i_reset  input  1  reset, asynchronous, active-low
- i_start  input  1  dump request pulse, sampled only in IDLE
- i_base_addr  input  BITS_SIZE  start byte address; bits [1:0] are forced to 0
- i_word_count  input  SIZE_MEM_DATA+1  number of words to dump, 0..2^SIZE_MEM_DATA
- o_addr_mem_debug  output  BITS_SIZE  drives the MEM stage debug address input
- i_mem_dato_debug  input  BITS_SIZE  MEM stage debug data output, valid 1 cycle after the address changes
- o_tx_data  output  8  byte to the transmitter
- o_tx_valid  output  1  o_tx_data is valid
- i_tx_ready  input  1  transmitter accepts the byte on this edge when o_tx_valid=1
- o_busy  output  1  dump in progress
- o_done  output  1  single-cycle pulse after the last byte is accepted, or after an empty request

## Operation
- States: IDLE, WAIT, SEND, DONE.
- IDLE
  - i_start=1 and i_word_count!=0: latch {i_base_addr[31:2],2'b00} into o_addr_mem_debug, latch count into remaining; o_busy<=1; go to WAIT.
  - i_start=1 and i_word_count==0: go to DONE; o_addr_mem_debug unchanged; no bytes sent.
- WAIT: one cycle for memory read latency. At the closing edge, capture i_mem_dato_debug into a 32-bit word register, set byte index=0, o_tx_valid<=1, o_tx_data<=word[31:24]; go to SEND.
- SEND
  - On each edge with o_tx_valid & i_tx_ready, the byte is accepted and the index advances: present word[23:16], then [15:8], then [7:0].
  - While i_tx_ready=0, o_tx_valid and o_tx_data hold stable. o_tx_valid never drops before acceptance.
  - On acceptance of byte 3 with remaining>1: remaining-=1, o_addr_mem_debug+=4 (mod 2^32, wraps 0xFFFFFFFC->0x00000000), o_tx_valid<=0, go to WAIT.
  - On acceptance of byte 3 with remaining==1: o_tx_valid<=0, o_busy<=0, go to DONE.
- DONE: o_done=1 for exactly this cycle, then return to IDLE.
- i_start outside IDLE is ignored; it is neither queued nor restarts the dump.
- o_addr_mem_debug holds its last value in IDLE and DONE.
- Counter width: remaining is SIZE_MEM_DATA+1 bits, so the full depth 2^SIZE_MEM_DATA is reachable.
- Asserting i_reset low at any time, including mid-byte, aborts the dump immediately. The block does not finish the current byte.

## Timing
- Reset values: state=IDLE, o_addr_mem_debug=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, remaining=0.
- Outputs are registered only. No combinational path from i_tx_ready or i_mem_dato_debug to any output.
- Start sampled at edge k: o_addr_mem_debug=base and o_busy=1 from k; data captured at k+1; o_tx_valid=1 from k+1.
- With i_tx_ready held 1, a word takes 5 cycles (1 WAIT + 4 SEND). N words take 5N cycles from the start edge to the last acceptance edge.
- o_done is high in the cycle after the last acceptance edge; o_busy is low in that same cycle.
- Empty request: o_done is high in the cycle after the start edge; o_busy stays 0.
- The word register is loaded only in WAIT. A change on i_mem_dato_debug during SEND has no effect on the bytes sent.

## Test plan
- Memory model word0=0x11223344, word1=0xAABBCCDD; base=0, count=2, ready=1 -> bytes 11,22,33,44,AA,BB,CC,DD; addresses 0 then 4; o_done 10 cycles after the start edge.
- Same dump with ready toggling 1-0-1 -> identical byte order; o_tx_data and o_tx_valid stable through every ready=0 cycle.
- base=0x00000007, count=1 -> address 0x00000004 used; 4 bytes sent.
- count=0 -> no o_tx_valid; o_done pulse in the cycle after start; o_busy stays 0.
- base=0xFFFFFFFC, count=2 -> addresses 0xFFFFFFFC then 0x00000000; i_start pulsed mid-dump -> ignored; 8 bytes total.
- i_reset low during byte 2 of word 0 -> all outputs go to reset values at once; after release, a fresh start dumps correctly from the new base.

Source files
------------

// File: rtl/mem_debug_dumper_if.sv
// Debug dump bundle: start/range request, MEM stage debug read port and the byte stream to the UART TX.
interface mem_debug_dumper_if #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 10
);
  logic                     i_start;
  logic [BITS_SIZE-1:0]     i_base_addr;
  logic [SIZE_MEM_DATA:0]   i_word_count;
  logic [BITS_SIZE-1:0]     o_addr_mem_debug;
  logic [BITS_SIZE-1:0]     i_mem_dato_debug;
  logic [7:0]               o_tx_data;
  logic                     o_tx_valid;
  logic                     i_tx_ready;
  logic                     o_busy;
  logic                     o_done;

  modport slave (
    input  i_start, i_base_addr, i_word_count, i_mem_dato_debug, i_tx_ready,
    output o_addr_mem_debug, o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_base_addr, i_word_count, i_mem_dato_debug, i_tx_ready,
    input  o_addr_mem_debug, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/mem_debug_dumper.sv
// Walks a word range of data memory via the debug port and streams each word MSB-first as 4 bytes.
// One read-latency cycle per word, then bytes held stable on o_tx_valid until i_tx_ready; all outputs registered.
module mem_debug_dumper #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 10
) (
  input logic                i_clk,
  input logic                i_reset,
  mem_debug_dumper_if.slave  dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [SIZE_MEM_DATA:0] CNT_ONE  = (SIZE_MEM_DATA+1)'(1);
  localparam logic [BITS_SIZE-1:0]   ADDR_STEP = BITS_SIZE'(4);

  logic [1:0]               state;
  logic [BITS_SIZE-1:0]     addr;
  logic [BITS_SIZE-1:0]     word;
  logic [1:0]               idx;
  logic [SIZE_MEM_DATA:0]   remaining;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     busy;
  logic                     done;

  // Byte presented after byte i of the word has been accepted.
  function automatic logic [7:0] byte_after(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_after = w[23:16];
      2'd1:    byte_after = w[15:8];
      default: byte_after = w[7:0];
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      word      <= '0;
      idx       <= 2'd0;
      remaining <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dbg.i_start) begin
            if (dbg.i_word_count != '0) begin
              addr      <= {dbg.i_base_addr[BITS_SIZE-1:2], 2'b00};
              remaining <= dbg.i_word_count;
              busy      <= 1'b1;
              state     <= S_WAIT;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_WAIT: begin
          // The only place the read data is sampled; later changes on the port are ignored.
          word     <= dbg.i_mem_dato_debug;
          idx      <= 2'd0;
          tx_data  <= dbg.i_mem_dato_debug[31:24];
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end

        S_SEND: begin
          if (tx_valid && dbg.i_tx_ready) begin
            if (idx == 2'd3) begin
              tx_valid <= 1'b0;
              if (remaining > CNT_ONE) begin
                remaining <= remaining - CNT_ONE;
                addr      <= addr + ADDR_STEP;
                state     <= S_WAIT;
              end else begin
                remaining <= '0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= S_DONE;
              end
            end else begin
              idx     <= idx + 2'd1;
              tx_data <= byte_after(word, idx);
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg.o_addr_mem_debug = addr;
  assign dbg.o_tx_data        = tx_data;
  assign dbg.o_tx_valid       = tx_valid;
  assign dbg.o_busy           = busy;
  assign dbg.o_done           = done;

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Directed bench: a word-addressed memory function feeds the debug port, a byte/address queue model checks the stream.
module tb_mem_debug_dumper;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic        tx_ready = 1'b1;
  logic        rdy_mode = 1'b0;
  logic [7:0]  rdy_cyc  = 8'd0;
  logic [31:0] noise    = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_byte[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  got[$];
  logic        hold_prev = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        checking  = 1'b0;

  always #5 i_clk = ~i_clk;

  mem_debug_dumper_if #(.BITS_SIZE(32), .SIZE_MEM_DATA(10)) dbg();

  mem_debug_dumper #(.BITS_SIZE(32), .SIZE_MEM_DATA(10)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .dbg     (dbg)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0000: memval = 32'h1122_3344;
      32'h0000_0004: memval = 32'hAABB_CCDD;
      default:       memval = {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign dbg.i_mem_dato_debug = memval(dbg.o_addr_mem_debug) ^ noise;
  assign dbg.i_tx_ready       = tx_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected byte stream: words from the aligned base upward, MSB first, address wrapping mod 2^32.
  task automatic plan(input logic [31:0] base, input int count);
    logic [31:0] a;
    logic [31:0] w;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < count; i++) begin
      w = memval(a);
      for (int b = 3; b >= 0; b--) begin
        exp_byte.push_back(w[8*b +: 8]);
        exp_addr.push_back(a);
      end
      a = a + 32'd4;
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    rdy_cyc  <= rdy_cyc + 8'd1;
    tx_ready <= rdy_mode ? ~rdy_cyc[0] : 1'b1;
  end

  always @(negedge i_clk) begin
    if (checking && i_reset) begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, dbg.o_tx_valid}, 32'd1);
        chk("hold_data", {24'd0, dbg.o_tx_data}, {24'd0, prev_data});
      end
      if (dbg.o_tx_valid) begin
        if (exp_byte.size() == 0) begin
          chk("extra_byte", {31'd0, dbg.o_tx_valid}, 32'd0);
        end else begin
          chk("tx_data", {24'd0, dbg.o_tx_data}, {24'd0, exp_byte[0]});
          chk("tx_addr", dbg.o_addr_mem_debug, exp_addr[0]);
          chk("busy_while_valid", {31'd0, dbg.o_busy}, 32'd1);
          if (tx_ready) begin
            got.push_back(dbg.o_tx_data);
            void'(exp_byte.pop_front());
            void'(exp_addr.pop_front());
          end
        end
      end
      hold_prev <= dbg.o_tx_valid && !tx_ready;
      prev_data <= dbg.o_tx_data;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  task automatic pulse_start(input logic [31:0] base, input int count);
    @(posedge i_clk);
    #1;
    plan(base, count);
    dbg.i_base_addr  = base;
    dbg.i_word_count = 11'(count);
    dbg.i_start      = 1'b1;
    @(posedge i_clk);
    #1;
    dbg.i_start = 1'b0;
  endtask

  // n counts edges after the start edge until o_done is seen high; -1 skips the latency check.
  task automatic run_dump(input logic [31:0] base, input int count, input int exp_n,
                          input bit use_noise, input int pulse_at);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    pulse_start(base, count);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge i_clk);
      if (count == 0) chk("empty_busy", {31'd0, dbg.o_busy}, 32'd0);
      if (dbg.o_done) begin
        seen = 1'b1;
      end else begin
        @(posedge i_clk);
        #1;
        n++;
        noise       = (use_noise && (n % 5 != 0)) ? $urandom : 32'd0;
        dbg.i_start = (n == pulse_at);
      end
    end
    noise       = 32'd0;
    dbg.i_start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (exp_n >= 0) chk("done_cycle", n, exp_n);
    chk("busy_at_done", {31'd0, dbg.o_busy}, 32'd0);
    chk("bytes_missing", exp_byte.size(), 32'd0);
    @(negedge i_clk);
    chk("done_width", {31'd0, dbg.o_done}, 32'd0);
  endtask

  task automatic chk_log(input string name, input logic [63:0] v, input int nb);
    chk({name, "_len"}, got.size(), nb);
    for (int i = 0; i < nb && i < got.size(); i++)
      chk(name, {24'd0, got[i]}, {24'd0, v[8*(nb-1-i) +: 8]});
    got.delete();
  endtask

  initial begin
    dbg.i_start      = 1'b0;
    dbg.i_base_addr  = 32'd0;
    dbg.i_word_count = 11'd0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_addr",  dbg.o_addr_mem_debug, 32'd0);
    chk("rst_data",  {24'd0, dbg.o_tx_data}, 32'd0);
    chk("rst_valid", {31'd0, dbg.o_tx_valid}, 32'd0);
    chk("rst_busy",  {31'd0, dbg.o_busy}, 32'd0);
    chk("rst_done",  {31'd0, dbg.o_done}, 32'd0);
    @(negedge i_clk);
    i_reset  = 1'b1;
    checking = 1'b1;

    // Two words, ready held high, read port scrambled outside the capture cycle.
    run_dump(32'h0000_0000, 2, 10, 1'b1, -1);
    chk_log("t1_bytes", 64'h1122_3344_AABB_CCDD, 8);

    // Same dump with ready toggling.
    rdy_mode = 1'b1;
    run_dump(32'h0000_0000, 2, -1, 1'b0, -1);
    chk_log("t2_bytes", 64'h1122_3344_AABB_CCDD, 8);
    rdy_mode = 1'b0;
    repeat (2) @(posedge i_clk);

    // Unaligned base is forced down to word alignment.
    run_dump(32'h0000_0007, 1, 5, 1'b0, -1);
    chk_log("t3_bytes", 64'h0000_0000_AABB_CCDD, 4);
    chk("t3_addr", dbg.o_addr_mem_debug, 32'h0000_0004);

    // Empty request: done right after the start edge, address untouched.
    run_dump(32'h0000_0040, 0, 0, 1'b0, -1);
    chk_log("t4_bytes", 64'd0, 0);
    chk("t4_addr", dbg.o_addr_mem_debug, 32'h0000_0004);

    // Address wrap, with a start pulse mid-dump that must be ignored.
    run_dump(32'hFFFF_FFFC, 2, 10, 1'b0, 3);
    chk_log("t5_bytes", 64'h0003_FFFC_1122_3344, 8);
    chk("t5_addr", dbg.o_addr_mem_debug, 32'h0000_0000);

    // Reset while the third byte of word 0 is on the bus.
    pulse_start(32'h0000_0000, 2);
    for (int i = 0; i < 50 && got.size() < 2; i++) begin
      @(posedge i_clk);
      #1;
    end
    chk("t6_reach", got.size(), 32'd2);
    #1;
    i_reset = 1'b0;
    #1;
    chk("t6_addr",  dbg.o_addr_mem_debug, 32'd0);
    chk("t6_data",  {24'd0, dbg.o_tx_data}, 32'd0);
    chk("t6_valid", {31'd0, dbg.o_tx_valid}, 32'd0);
    chk("t6_busy",  {31'd0, dbg.o_busy}, 32'd0);
    chk("t6_done",  {31'd0, dbg.o_done}, 32'd0);
    exp_byte.delete();
    exp_addr.delete();
    got.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    run_dump(32'h0000_0100, 1, 5, 1'b0, -1);
    chk_log("t6_bytes", 64'h0000_0000_FEFF_0100, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
